// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the RISC-V memory arbiter.
//   state_t : arbiter FSM states
//   owner_t : which requester owns the outstanding access
//   XLEN    : data/address width
//   BE_W    : byte-enable width (one bit per byte of XLEN)
package riscv_mem_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  // Reads always fetch the full word.
  localparam logic [BE_W-1:0] BE_ALL = '1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Shares one fixed-latency single-port memory between the instruction-fetch
// port and the data (load/store) port. One access is outstanding at a time.
// Data requests win contention unless fetch has already been passed over
// STARVE_MAX consecutive times.
//
// Parameters
//   LAT        : memory read latency, mem_en cycle to mem_rdata valid (1..7)
//   STARVE_MAX : data grants allowed while fetch waits (1..15)
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   if_req_* / if_rsp_*        : fetch request handshake and response pulse
//   d_req_* / d_rsp_*          : data request handshake and response pulse
//   mem_en/we/addr/wdata/be    : registered memory command, qualified by mem_en
//   mem_rdata                  : read data, valid LAT cycles after mem_en
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [XLEN-1:0] if_req_addr,
  output logic            if_rsp_valid,
  output logic [XLEN-1:0] if_rsp_data,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic [XLEN-1:0] d_req_addr,
  input  logic            d_req_we,
  input  logic [XLEN-1:0] d_req_wdata,
  input  logic [BE_W-1:0] d_req_be,
  output logic            d_rsp_valid,
  output logic [XLEN-1:0] d_rsp_data,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [2:0] LAT_LAST   = 3'(LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, next_state;
  owner_t     owner;
  logic [2:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       grant_if, grant_d;
  logic       last_wait;

  assign last_wait = (state == WAIT) && (lat_cnt == LAT_LAST);

  // Picker and next-state logic. Grants exist only in IDLE and never while
  // reset is asserted, so both readies read 0 during reset.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned -- otherwise synthesis infers a latch.
    next_state = state;
    grant_if   = 1'b0;
    grant_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!reset) begin
          grant_if = if_req_valid && (!d_req_valid || starve_cnt == STARVE_LIM);
          grant_d  = d_req_valid && !grant_if;
          if (grant_if || grant_d) next_state = ISSUE;
        end
      end
      ISSUE:   next_state = WAIT;
      WAIT:    if (lat_cnt == LAT_LAST) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign if_req_ready = grant_if;
  assign d_req_ready  = grant_d;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Datapath: memory command, owner, counters and response registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      owner        <= OWN_IF;
      lat_cnt      <= '0;
      starve_cnt   <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_data   <= '0;
    end else begin
      mem_en       <= grant_if || grant_d;
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;

      // The command registers hold between accesses; only mem_en qualifies them.
      if (grant_if) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_req_addr;
        mem_wdata <= '0;
        mem_be    <= BE_ALL;
        owner     <= OWN_IF;
      end else if (grant_d) begin
        mem_we    <= d_req_we;
        mem_addr  <= d_req_addr;
        mem_wdata <= d_req_wdata;
        mem_be    <= d_req_we ? d_req_be : BE_ALL;
        owner     <= OWN_D;
      end

      // Starvation tracking only moves while arbitrating in IDLE; a data
      // grant counts only if fetch was actually waiting.
      if (state == IDLE) begin
        if (grant_if || !if_req_valid) starve_cnt <= '0;
        else if (grant_d && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
      end

      lat_cnt <= (state == WAIT) ? lat_cnt + 3'd1 : 3'd0;

      // mem_rdata is valid in the last WAIT cycle; registering it here puts
      // the response pulse in RESP. mem_we still holds the access type.
      if (last_wait) begin
        if (owner == OWN_IF) begin
          if_rsp_valid <= 1'b1;
          if_rsp_data  <= mem_rdata;
        end else begin
          d_rsp_valid <= 1'b1;
          d_rsp_data  <= mem_we ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule
